// File: rtl/pqr_sweep_checker_pkg.sv
// ----------------------------------------------------------------------------
// pqr_sweep_checker_pkg
// Shared definitions for the P/Q/R truth-table sweep checker.
//   state_t     : sweep controller states (IDLE / DRIVE / DONE)
//   IDX_W       : width of the combination index driving {P,Q,R}
//   TABLE_W     : number of truth-table entries (2**IDX_W)
//   CNT_W       : width of the mismatch count (must hold 0..TABLE_W)
//   HOLD_CNT_W  : width of the per-combination hold counter
//   popcount()  : number of set bits in a truth-table sized vector
// ----------------------------------------------------------------------------
package pqr_sweep_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int IDX_W      = 3;
    localparam int TABLE_W    = 8;
    localparam int CNT_W      = 4;
    localparam int HOLD_CNT_W = 8;

    // Mismatch count is the popcount of (captured XOR golden).
    function automatic logic [CNT_W-1:0] popcount(input logic [TABLE_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < TABLE_W; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pqr_sweep_checker_sweep_hold_timer.sv
// ----------------------------------------------------------------------------
// sweep_hold_timer
// Counts the cycles a P/Q/R combination has been held and raises a
// sample strobe in the last of HOLD cycles, then wraps back to zero.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   clear  : restart counting from zero (new sweep launched)
//   enable : count only while the sweep is driving combinations
//   sample : high in the cycle the current combination should be sampled
// ----------------------------------------------------------------------------
module sweep_hold_timer
    import pqr_sweep_checker_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic sample
);

    localparam logic [HOLD_CNT_W-1:0] LAST = HOLD_CNT_W'(HOLD - 1);

    logic [HOLD_CNT_W-1:0] count;

    // With HOLD=1 LAST is zero, so every enabled cycle is a sample cycle.
    assign sample = enable && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= sample ? '0 : count + HOLD_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pqr_sweep_checker.sv
// ----------------------------------------------------------------------------
// pqr_sweep_checker
// Steps a 3-input gate through all eight P/Q/R combinations, holds each
// for HOLD cycles, samples F at the end of each hold, and compares the
// captured truth table against a golden table.
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   start        : one-cycle sweep request (ignored while busy)
//   expected     : golden truth table, bit i = F expected at {P,Q,R}=i
//   F            : gate-under-test output, combinational from P/Q/R
//   P, Q, R      : registered gate inputs (MSB..LSB of the index)
//   busy         : sweep in progress
//   done         : sweep complete, held until next start or reset
//   pass         : captured table equals golden table (valid with done)
//   table_out    : captured truth table
//   mismatch_cnt : number of differing truth-table bits (valid with done)
// ----------------------------------------------------------------------------
module pqr_sweep_checker
    import pqr_sweep_checker_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TABLE_W-1:0] expected,
    input  logic               F,
    output logic               P,
    output logic               Q,
    output logic               R,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [TABLE_W-1:0] table_out,
    output logic [CNT_W-1:0]   mismatch_cnt
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_W - 1);

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               sample;
    logic               launch;
    logic [TABLE_W-1:0] table_next;

    // A start only counts when no sweep is running.
    assign launch = start && (state != DRIVE);

    assign {P, Q, R} = idx;

    sweep_hold_timer #(
        .HOLD (HOLD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (launch),
        .enable (state == DRIVE),
        .sample (sample)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      if (sample && (idx == IDX_LAST)) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state == DRIVE);
        done = (state == DONE);
    end

    // The table as it will look after this cycle's sample, so the final
    // compare can include the bit being written on the last sample.
    always_comb begin
        table_next      = table_out;
        table_next[idx] = F;
    end

    // Index, captured table and compare results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            table_out    <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
        end else if (launch) begin
            idx          <= '0;
            table_out    <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
        end else if ((state == DRIVE) && sample) begin
            table_out <= table_next;
            if (idx == IDX_LAST) begin
                idx          <= '0;
                pass         <= (table_next == expected);
                mismatch_cnt <= popcount(table_next ^ expected);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: doc/pqr_sweep_checker.md
PQR_SWEEP_CHECKER -- requirements
Module: pqr_sweep_checker

Interface
REQ-001 Parameter HOLD, default 4, cycles each P/Q/R combination is held before F is sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a sweep.
REQ-005 expected  input  8  golden truth table; bit i is the expected F for {P,Q,R}=i.
REQ-006 F  input  1  output of the combinational gate under test, driven from P/Q/R.
REQ-007 P  output  1  gate input, MSB of the current combination index.
REQ-008 Q  output  1  gate input, middle bit of the index.
REQ-009 R  output  1  gate input, LSB of the index.
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  high once a sweep completes; held until the next start or reset.
REQ-012 pass  output  1  valid while done is high; 1 when table_out equals expected.
REQ-013 table_out  output  8  captured truth table; bit i is F sampled at index i.
REQ-014 mismatch_cnt  output  4  popcount(table_out XOR expected), valid while done is high, range 0..8.

Function
REQ-015 FSM states: IDLE, DRIVE, DONE.
REQ-016 IDLE or DONE with start=1 -> DRIVE on the next edge; idx=0, hold counter=0, table_out cleared, done/pass/mismatch_cnt cleared.
REQ-017 {P,Q,R} SHALL equal the registered 3-bit idx at all times; P/Q/R are registered outputs and are glitch-free.
REQ-018 DRIVE: hold counter increments each cycle; in the cycle it equals HOLD-1, F is written into table_out[idx] and the counter returns to 0.
REQ-019 On that sample cycle: if idx<7, idx increments; if idx==7, FSM goes to DONE and idx wraps to 0.
REQ-020 In the DONE entry cycle, pass and mismatch_cnt are registered from the final table including bit 7; done rises in that same cycle.
REQ-021 Latency: start seen at edge k -> first DRIVE cycle k+1 -> done high at edge k+1+8*HOLD.
REQ-022 busy = (state==DRIVE); start while busy is ignored, with no restart and no effect.
REQ-023 start in DONE begins a new sweep per REQ-016; done drops on the same edge DRIVE is entered.
REQ-024 HOLD=1 SHALL sample on every DRIVE cycle, giving 8 DRIVE cycles in total.
REQ-025 F is not synchronised; it is same-domain combinational from P/Q/R, and HOLD≥1 guarantees a full cycle of settle time.

Reset
REQ-026 rst=1 forces, asynchronously: state=IDLE, idx=0, hold counter=0, P=Q=R=0, busy=0, done=0, pass=0, table_out=8'h00, mismatch_cnt=0.
REQ-027 rst asserted mid-sweep aborts the sweep; no partial result is flagged; a fresh start is required after release.
REQ-028 On the first edge after rst deasserts, start is honoured normally.

Structure
REQ-029 A shared package holds the state enum (IDLE/DRIVE/DONE), IDX_W=3, TABLE_W=8, CNT_W=4.
REQ-030 One sub-module, sweep_hold_timer, holds the 8-bit hold counter and produces a sample-strobe; the FSM, idx, table, and compare logic stay in pqr_sweep_checker.

Verification
REQ-031 HOLD=2, F=majority(P,Q,R), expected=8'hE8, pulse start -> done at start+17 cycles, table_out=8'hE8, pass=1, mismatch_cnt=0.
REQ-032 HOLD=2, F=XOR3, expected=8'hE8 -> table_out=8'h96, pass=0, mismatch_cnt=6.
REQ-033 HOLD=25, F=P&Q&R -> P/Q/R step 000..111, each held exactly 25 cycles; table_out=8'h80.
REQ-034 Pulse start again at idx=3 during a sweep -> ignored; result and timing identical to an uninterrupted sweep.
REQ-035 Assert rst during idx=5 -> all outputs zero immediately; then start -> a full 8-combination sweep completes correctly.
REQ-036 HOLD=1, F=R -> done 9 cycles after start, table_out=8'hAA; a second start from DONE clears done the next cycle and repeats the same result.
